// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory port arbiter: FSM encodings, grant IDs, wait limit.
package mem_port_arbiter_pkg;

    localparam int unsigned ARB_STATE_W      = 2;
    localparam int unsigned WAIT_W           = 4;
    localparam int unsigned WE_W             = 4;
    localparam int unsigned MAX_WAIT_DEFAULT = 15;

    localparam logic [ARB_STATE_W-1:0] ARB_IDLE  = 2'd0;
    localparam logic [ARB_STATE_W-1:0] ARB_GNT_I = 2'd1;
    localparam logic [ARB_STATE_W-1:0] ARB_GNT_D = 2'd2;
    localparam logic [ARB_STATE_W-1:0] ARB_RESP  = 2'd3;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant decision between fetch and data requesters.
// ARB_ROUND_ROBIN_EN selects alternating grants on collisions; otherwise data wins.
module arb_grant_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_vld_c,
    output logic grant_c
);

    always_comb begin
        grant_vld_c = req_i | req_d;
`ifdef ARB_ROUND_ROBIN_EN
        // On a collision, favour whoever was not served last
        if (req_i && req_d) begin
            grant_c = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else begin
            grant_c = req_d ? GNT_D : GNT_I;
        end
`else
        grant_c = req_d ? GNT_D : GNT_I;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-ported memory with wait-state timeout.
// Optional macro ARB_ROUND_ROBIN_EN enables round-robin collision handling.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned AWIDTH   = 16,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [AWIDTH-1:0] i_addr,
    output logic              i_ack,
    output logic [XLEN-1:0]   i_rdata,
    input  logic              d_req,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [WE_W-1:0]   d_we,
    output logic              d_ack,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_req,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [WE_W-1:0]   mem_we,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              i_busy,
    output logic              d_busy,
    output logic              bus_err
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [ARB_STATE_W-1:0] state, state_nxt;
    logic [WAIT_W-1:0]      wait_cnt, wait_cnt_nxt;
    logic                   mem_req_nxt, i_ack_nxt, d_ack_nxt, bus_err_nxt;
    logic [AWIDTH-1:0]      mem_addr_nxt;
    logic [XLEN-1:0]        mem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
    logic [WE_W-1:0]        mem_we_nxt;
    logic                   grant_vld_c, grant_c;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant, last_grant_nxt;
`endif

    arb_grant_sel u_grant_sel (
        .req_i       (i_req),
        .req_d       (d_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant),
`endif
        .grant_vld_c (grant_vld_c),
        .grant_c     (grant_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        mem_req_nxt   = mem_req;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_we_nxt    = mem_we;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
        bus_err_nxt   = bus_err;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_nxt = last_grant;
`endif
        case (state)
            ARB_IDLE: begin
                if (grant_vld_c) begin
                    mem_req_nxt  = 1'b1;
                    wait_cnt_nxt = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_nxt = grant_c;
`endif
                    if (grant_c == GNT_D) begin
                        state_nxt     = ARB_GNT_D;
                        mem_addr_nxt  = d_addr;
                        mem_wdata_nxt = d_wdata;
                        mem_we_nxt    = d_we;
                    end else begin
                        state_nxt     = ARB_GNT_I;
                        mem_addr_nxt  = i_addr;
                        mem_wdata_nxt = '0;
                        mem_we_nxt    = '0;
                    end
                end
            end
            ARB_GNT_I, ARB_GNT_D: begin
                if (mem_ready || (wait_cnt == WAIT_LIMIT)) begin
                    // Normal completion or timeout both end with one ack via RESP
                    state_nxt   = ARB_RESP;
                    mem_req_nxt = 1'b0;
                    bus_err_nxt = bus_err | ~mem_ready;
                    if (state == ARB_GNT_D) begin
                        d_ack_nxt   = 1'b1;
                        d_rdata_nxt = mem_ready ? mem_rdata : '0;
                    end else begin
                        i_ack_nxt   = 1'b1;
                        i_rdata_nxt = mem_ready ? mem_rdata : '0;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ARB_RESP: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            bus_err   <= 1'b0;
        end else begin
            wait_cnt  <= wait_cnt_nxt;
            mem_req   <= mem_req_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_we    <= mem_we_nxt;
            i_ack     <= i_ack_nxt;
            d_ack     <= d_ack_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_I;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end
`endif

    assign i_busy = i_req & ~i_ack;
    assign d_busy = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter; honours ARB_ROUND_ROBIN_EN if defined.
module tb_mem_port_arbiter;

    localparam int MAX_W = 15;

    logic        clk;
    logic        rst_n;
    logic        i_req, d_req, mem_ready;
    logic [15:0] i_addr, d_addr;
    logic [31:0] d_wdata, mem_rdata;
    logic [3:0]  d_we;
    logic        i_ack, d_ack, mem_req, i_busy, d_busy, bus_err;
    logic [31:0] i_rdata, d_rdata, mem_wdata;
    logic [15:0] mem_addr;
    logic [3:0]  mem_we;

    int          n_chk;
    int          n_err;
    logic        berr_m;
    logic [31:0] irdata_m, drdata_m;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_m;
`endif

    mem_port_arbiter #(.XLEN(32), .AWIDTH(16), .MAX_WAIT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_we      (d_we),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .i_busy    (i_busy),
        .d_busy    (d_busy),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One scenario: requests raised together, schedule derived from wait-state arithmetic
    task automatic run_scn(input bit use_i, input bit use_d,
                           input logic [15:0] ia, input logic [15:0] da,
                           input logic [31:0] dw, input logic [3:0] dwe,
                           input int wi, input int wd, input bit toi, input bit tod,
                           input logic [31:0] ri, input logic [31:0] rd);
        bit          who[3];
        bit          to[3];
        int          g[3], w[3];
        logic [15:0] ad[3];
        logic [31:0] wdv[3], rv[3];
        logic [3:0]  wev[3];
        int          n, k, last_e;
        bit          first_d, want, is_d, xm, xi, xd, rdy;
        n = 0;
        first_d = use_d;
`ifdef ARB_ROUND_ROBIN_EN
        if (use_i && use_d && last_m) first_d = 1'b0;
`endif
        for (int p = 0; p < 3; p++) begin
            is_d = (p != 1);
            want = (p == 0) ? first_d : ((p == 1) ? use_i : (use_d && !first_d));
            if (want) begin
                who[n] = is_d;
                to[n]  = is_d ? tod : toi;
                w[n]   = to[n] ? MAX_W : (is_d ? wd : wi);
                ad[n]  = is_d ? da : ia;
                wdv[n] = is_d ? dw : 32'h0;
                wev[n] = is_d ? dwe : 4'h0;
                rv[n]  = is_d ? rd : ri;
                g[n]   = (n == 0) ? 0 : g[n-1] + 3 + w[n-1];
                n++;
            end
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_m = who[n-1];
`endif
        i_req = use_i; i_addr = ia;
        d_req = use_d; d_addr = da; d_wdata = dw; d_we = dwe;
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom();
        last_e = g[n-1] + 1 + w[n-1];
        for (int e = 0; e <= last_e; e++) begin
            @(posedge clk); @(negedge clk);
            xm = 0; xi = 0; xd = 0; rdy = 0; k = -1;
            for (int j = 0; j < n; j++) begin
                if (e >= g[j] && e <= g[j] + w[j]) begin xm = 1; k = j; end
                if (!to[j] && e == g[j] + w[j]) rdy = 1;
                if (e == g[j] + 1 + w[j]) begin
                    if (to[j]) berr_m = 1'b1;
                    if (who[j]) begin xd = 1; drdata_m = to[j] ? 32'h0 : rv[j]; end
                    else        begin xi = 1; irdata_m = to[j] ? 32'h0 : rv[j]; end
                end
            end
            chk("mem_req", 32'(mem_req), 32'(xm));
            if (k >= 0) begin
                chk("mem_addr", 32'(mem_addr), 32'(ad[k]));
                chk("mem_we", 32'(mem_we), 32'(wev[k]));
                if (who[k]) chk("mem_wdata", mem_wdata, wdv[k]);
            end
            chk("i_ack", 32'(i_ack), 32'(xi));
            chk("d_ack", 32'(d_ack), 32'(xd));
            chk("i_rdata", i_rdata, irdata_m);
            chk("d_rdata", d_rdata, drdata_m);
            chk("bus_err", 32'(bus_err), 32'(berr_m));
            chk("i_busy", 32'(i_busy), 32'(i_req & ~xi));
            chk("d_busy", 32'(d_busy), 32'(d_req & ~xd));
            if (xi) i_req = 1'b0;
            if (xd) d_req = 1'b0;
            // Granted requester's inputs change freely; the latched copy must be used
            if (k >= 0 && e == g[k]) begin
                if (who[k]) begin
                    d_addr = 16'($urandom()); d_wdata = $urandom(); d_we = 4'($urandom());
                end else begin
                    i_addr = 16'($urandom());
                end
            end
            mem_ready = xm ? rdy : 1'($urandom_range(0, 1));
            mem_rdata = rdy ? rv[k] : $urandom();
        end
        repeat (1 + $urandom_range(0, 2)) begin
            @(posedge clk); @(negedge clk);
            chk("idle_mem_req", 32'(mem_req), 32'h0);
            chk("idle_i_ack", 32'(i_ack), 32'h0);
            chk("idle_d_ack", 32'(d_ack), 32'h0);
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
        end
    endtask

    task automatic run_rand();
        int  mode, wi, wd;
        bit  toi, tod;
        mode = $urandom_range(1, 3);
        wi = ($urandom_range(0, 7) == 0) ? MAX_W : $urandom_range(0, 4);
        wd = ($urandom_range(0, 7) == 0) ? MAX_W : $urandom_range(0, 4);
        toi = ($urandom_range(0, 9) == 0);
        tod = ($urandom_range(0, 9) == 0);
        run_scn(mode[0], mode[1], 16'($urandom()), 16'($urandom()), $urandom(),
                4'($urandom()), wi, wd, toi, tod, $urandom(), $urandom());
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        berr_m = 1'b0; irdata_m = '0; drdata_m = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_m = 1'b0;
`endif
        rst_n = 1'b0;
        i_req = 0; d_req = 0; i_addr = '0; d_addr = '0; d_wdata = '0; d_we = '0;
        mem_ready = 0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_i_ack", 32'(i_ack), 32'h0);
        chk("rst_d_ack", 32'(d_ack), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_i_busy", 32'(i_busy), 32'h0);
        chk("rst_d_busy", 32'(d_busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_scn(1, 0, 16'h0040, 16'h0, 32'h0, 4'h0, 0, 0, 0, 0, 32'h00500093, 32'h0);
        run_scn(0, 1, 16'h0, 16'h1000, 32'hDEADBEEF, 4'b0011, 0, 3, 0, 0, 32'h0, 32'h12345678);
        repeat (3)
            run_scn(1, 1, 16'($urandom()), 16'($urandom()), $urandom(), 4'($urandom()),
                    0, 0, 0, 0, $urandom(), $urandom());
        run_scn(0, 1, 16'h2000, 16'h2004, 32'h0, 4'h0, 0, MAX_W, 0, 0, 32'h0, 32'hCAFEF00D);
        run_scn(0, 1, 16'h0, 16'h3000, 32'h0, 4'h0, 0, 0, 0, 1, 32'h0, 32'h55AA55AA);
        run_scn(1, 0, 16'h0044, 16'h0, 32'h0, 4'h0, 1, 0, 0, 0, 32'h00100113, 32'h0);
        repeat (40) run_rand();

        // Reset while a fetch is granted: everything clears, no ack appears
        i_req = 1'b1; i_addr = 16'h0123; mem_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pre_rst_mem_req", 32'(mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_req", 32'(mem_req), 32'h0);
        chk("async_i_ack", 32'(i_ack), 32'h0);
        chk("async_bus_err", 32'(bus_err), 32'h0);
        chk("async_mem_addr", 32'(mem_addr), 32'h0);
        chk("async_i_rdata", i_rdata, 32'h0);
        chk("async_d_rdata", d_rdata, 32'h0);
        i_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("in_rst_i_ack", 32'(i_ack), 32'h0);
        end
        rst_n = 1'b1;
        berr_m = 1'b0; irdata_m = '0; drdata_m = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_m = 1'b0;
`endif
        @(negedge clk);
        run_scn(1, 0, 16'h0123, 16'h0, 32'h0, 4'h0, 2, 0, 0, 0, 32'h0badc0de, 32'h0);
        run_scn(1, 1, 16'h0200, 16'h0300, 32'h11223344, 4'hF, 1, 0, 0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (read-only) and data memory access (read/write, byte enables).
- Sits between the core's fetch/memory-access stages and the external memory.
- Converts both requesters' level-request / one-cycle-ack handshakes into one downstream request/ready transaction, tolerating memory wait states.
- Exports busy flags that the phase state machine uses as stall sources.

Parameters:
- XLEN, 32, data width.
- AWIDTH, 16, byte address width of the shared memory port.
- MAX_WAIT, 15, downstream wait-state counter limit. Width is 4 bits; must be ≤ 15.

Ports:
- clk  in  1  CPU clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AWIDTH  fetch address
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle
- i_rdata  out  XLEN  fetched word
- d_req  in  1  data request, held until d_ack
- d_addr  in  AWIDTH  data address
- d_wdata  in  XLEN  write data
- d_we  in  4  byte write enables; 0 = read
- d_ack  out  1  one-cycle pulse; d_rdata valid this cycle
- d_rdata  out  XLEN  read data
- mem_req  out  1  downstream request, held until mem_ready
- mem_addr  out  AWIDTH  downstream address
- mem_wdata  out  XLEN  downstream write data
- mem_we  out  4  downstream byte enables
- mem_ready  in  1  downstream completion; mem_rdata valid
- mem_rdata  in  XLEN  downstream read data
- i_busy  out  1  fetch pending or in flight (stall_fetch source)
- d_busy  out  1  data pending or in flight (stall_memoryaccess source)
- bus_err  out  1  sticky: downstream exceeded MAX_WAIT

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, wait counter 0, last-grant = I.
- FSM states: IDLE, GNT_I, GNT_D, RESP.
- IDLE:
  - d_req=1 → GNT_D.
  - else i_req=1 → GNT_I.
  - Address, data and we are latched into the mem_* registers on the same edge.
  - mem_req rises one cycle after the request is sampled.
- GNT_x:
  - mem_req, mem_addr, mem_wdata, mem_we held stable.
  - Wait counter increments each cycle that mem_ready=0.
  - On mem_ready=1: capture mem_rdata into x_rdata, drop mem_req, pulse x_ack on the next cycle, go to RESP.
- RESP:
  - x_ack=1 for exactly one cycle, then IDLE.
  - Requester drops x_req in the ack cycle; IDLE re-samples only the cycle after RESP, so a stale req is never re-granted.
- Minimum latency: req sampled at edge 0, mem_req at cycle 1, mem_ready at cycle 1 gives ack at cycle 2. Back-to-back throughput: 1 transaction per 3 cycles.
- Write transactions: d_rdata = mem_rdata as returned; the core ignores it.
- x_rdata holds its value until the next ack for the same requester.
- Priority (default): fixed, data over instruction.
- Simultaneous i_req and d_req in IDLE:
  - D is served first; I is served next.
  - i_busy stays 1 throughout.
- i_busy = i_req & ~i_ack. d_busy = d_req & ~d_ack. Both are combinational from registered state and inputs.
- Requester inputs change while granted: ignored; the latched copy is used.
- Wait limit (counter reaches MAX_WAIT with mem_ready=0):
  - set bus_err, drop mem_req, pulse x_ack with x_rdata = 0, return to IDLE.
  - bus_err clears only on reset.
- mem_ready while in IDLE or RESP: ignored.
- Reset asserted mid-transaction: immediately IDLE, mem_req=0, no ack is issued. Requesters re-request after reset.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, grant goes to the requester not served last (last-grant register, updated on each grant).
- Defined, single requester: it is granted regardless of last-grant.
- Undefined: fixed data-over-instruction priority; the last-grant register is not instantiated.

Decomposition:
- Shared package/header (alongside core_general.vh):
  - FSM state encodings ARB_IDLE, ARB_GNT_I, ARB_GNT_D, ARB_RESP (2 bits).
  - Grant IDs GNT_I=0, GNT_D=1.
  - Default MAX_WAIT.
- One natural sub-module: arb_grant_sel, the combinational grant decision (req_i, req_d, last_grant → grant). It holds the ARB_ROUND_ROBIN_EN logic.
- FSM, wait counter and datapath registers stay in the top module.

Test Plan:
1. Single fetch: i_req=1, i_addr=0x0040; memory returns mem_ready at cycle 1 with 0x00500093 → mem_req at cycle 1 only, i_ack pulse at cycle 2, i_rdata=0x00500093, d_ack stays 0.
2. Data write with wait states: d_req=1, d_addr=0x1000, d_wdata=0xDEADBEEF, d_we=4'b0011, mem_ready delayed 3 cycles → mem_* stable for 4 cycles, one d_ack, mem_we=0011, d_busy high until the ack.
3. Collision (fixed priority): i_req and d_req rise in the same cycle → data transaction first, then fetch. i_ack is exactly 3 cycles after d_ack when ready has zero wait. Never two acks in one cycle.
4. Collision with ARB_ROUND_ROBIN_EN: three consecutive simultaneous request pairs → grant order D, I, D, I, D, I.
5. Timeout: d_req, mem_ready held 0 → after MAX_WAIT=15 wait cycles: bus_err=1, d_ack pulse with d_rdata=0. A following fetch completes normally and bus_err stays 1.
6. Reset mid-transaction: rst_n low during GNT_I → all outputs 0 asynchronously, no i_ack. After release and re-request, a normal fetch completes.
